// File: rtl/regfile_req_rsp.sv
// rtl/regfile_req_rsp.sv - request/response register bank with flat register output
// Optional byte write strobes: define REGFILE_REQ_RSP_WSTRB_EN.
module regfile_req_rsp #(
    parameter int               WIDTH     = 32,
    parameter int               NUM_REGS  = 16,
    parameter int               ADDR_W    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [WIDTH-1:0]          req_wdata,
`ifdef REGFILE_REQ_RSP_WSTRB_EN
    input  logic [(WIDTH+7)/8-1:0]    req_wstrb,
`endif
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WIDTH-1:0]          rsp_rdata,
    output logic                      rsp_err,
    output logic [NUM_REGS*WIDTH-1:0] regs_q
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    logic [0:0]       state;
    logic             accept;
    logic             in_range;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] wmask;

    assign req_ready = (state == ST_IDLE) & rstn;
    assign accept    = req_valid & req_ready;
    assign rsp_valid = (state == ST_RESP);

    // Address decode doubles as the range check: only indices below NUM_REGS match.
    always_comb begin
        in_range = 1'b0;
        rd_data  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (req_addr == ADDR_W'(i)) begin
                in_range = 1'b1;
                rd_data  = regs_q[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef REGFILE_REQ_RSP_WSTRB_EN
    always_comb begin
        wmask = '0;
        for (int b = 0; b < WIDTH; b++) begin
            wmask[b] = req_wstrb[b/8];
        end
    end
`else
    assign wmask = '1;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            regs_q <= {NUM_REGS{RESET_VAL}};
        end else if (accept && req_write) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (req_addr == ADDR_W'(i)) begin
                    regs_q[i*WIDTH +: WIDTH] <= (regs_q[i*WIDTH +: WIDTH] & ~wmask)
                                              | (req_wdata & wmask);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_RESP;
                        rsp_err   <= ~in_range;
                        rsp_rdata <= (!req_write && in_range) ? rd_data : '0;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_req_rsp.sv
// tb/tb_regfile_req_rsp.sv - directed and random checks of regfile_req_rsp against an array model
module tb_regfile_req_rsp;

    localparam int          WIDTH  = 32;
    localparam int          NREGS  = 12;
    localparam int          ADDR_W = 4;
    localparam logic [31:0] RV     = 32'hA5A5_0000;

    logic              clk = 1'b0;
    logic              rstn;
    logic              req_valid, req_ready, req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [31:0]       rsp_rdata;
    logic [NREGS*WIDTH-1:0] regs_q;

    logic [31:0] model [NREGS];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_req_rsp #(
        .WIDTH(WIDTH), .NUM_REGS(NREGS), .ADDR_W(ADDR_W), .RESET_VAL(RV)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef REGFILE_REQ_RSP_WSTRB_EN
        .req_wstrb(req_wstrb),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .regs_q(regs_q)
    );

    task automatic check(input string tag, input logic [NREGS*WIDTH-1:0] obs,
                         input logic [NREGS*WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREGS*WIDTH-1:0] model_flat();
        logic [NREGS*WIDTH-1:0] f;
        for (int i = 0; i < NREGS; i++) f[i*WIDTH +: WIDTH] = model[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) model[i] = RV;
    endtask

    // Issues one request, holds the response for 'delay' cycles, then completes it.
    task automatic do_req(input logic wr, input int addr, input logic [31:0] data,
                          input logic [3:0] strb, input int delay);
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          n;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = ADDR_W'(addr);
        req_wdata = data;
        req_wstrb = strb;
        rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_before_accept", {383'd0, req_ready}, {383'd0, 1'b1});
        exp_err   = (addr >= NREGS);
        exp_rdata = (!wr && !exp_err) ? model[addr] : 32'd0;
        if (wr && !exp_err) begin
`ifdef REGFILE_REQ_RSP_WSTRB_EN
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[addr][8*b +: 8] = data[8*b +: 8];
`else
            model[addr] = data;
`endif
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_wdata = $urandom;
        @(negedge clk);
        check("rsp_valid_latency", {383'd0, rsp_valid}, {383'd0, 1'b1});
        check("rsp_rdata", {352'd0, rsp_rdata}, {352'd0, exp_rdata});
        check("rsp_err", {383'd0, rsp_err}, {383'd0, exp_err});
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            check("rsp_hold_valid", {383'd0, rsp_valid}, {383'd0, 1'b1});
            check("rsp_hold_rdata", {352'd0, rsp_rdata}, {352'd0, exp_rdata});
            check("req_ready_in_resp", {383'd0, req_ready}, {383'd0, 1'b0});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("rsp_valid_after_hs", {383'd0, rsp_valid}, {383'd0, 1'b0});
        check("req_ready_after_hs", {383'd0, req_ready}, {383'd0, 1'b1});
        check("regs_q", regs_q, model_flat());
    endtask

    initial begin
        rstn = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b0;
        model_reset();

        // Reset state
        #12;
        check("reset_req_ready", {383'd0, req_ready}, {383'd0, 1'b0});
        check("reset_rsp_valid", {383'd0, rsp_valid}, {383'd0, 1'b0});
        check("reset_rsp_rdata", {352'd0, rsp_rdata}, 384'd0);
        check("reset_rsp_err", {383'd0, rsp_err}, 384'd0);
        check("reset_regs", regs_q, {NREGS{RV}});
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("req_ready_after_reset", {383'd0, req_ready}, {383'd0, 1'b1});

        // Write then read back
        do_req(1'b1, 3, 32'hDEAD_BEEF, 4'hF, 0);
        do_req(1'b0, 3, 32'h0, 4'h0, 0);
        check("reg3_value", {352'd0, regs_q[3*WIDTH +: WIDTH]}, {352'd0, 32'hDEAD_BEEF});

        // Backpressured read
        do_req(1'b0, 3, 32'h0, 4'h0, 5);

        // Out-of-range write and read
        do_req(1'b1, 13, 32'h5555_AAAA, 4'hF, 1);
        do_req(1'b0, 13, 32'h0, 4'h0, 0);
        do_req(1'b0, 15, 32'h0, 4'h0, 0);
        do_req(1'b0, 11, 32'h0, 4'h0, 0);

        // Reset while a write response is pending
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd1;
        req_wdata = 32'h1234; req_wstrb = 4'hF; rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_rsp_valid", {383'd0, rsp_valid}, {383'd0, 1'b1});
        check("pre_reset_reg1", {352'd0, regs_q[WIDTH +: WIDTH]}, {352'd0, 32'h1234});
        #1 rstn = 1'b0;
        #1;
        check("async_reset_rsp_valid", {383'd0, rsp_valid}, 384'd0);
        check("async_reset_regs", regs_q, {NREGS{RV}});
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_replay_rsp_valid", {383'd0, rsp_valid}, 384'd0);
        end
        rsp_ready = 1'b0;

        // Byte strobes
        do_req(1'b1, 0, 32'hFFFF_FFFF, 4'hF, 0);
        do_req(1'b1, 0, 32'h0000_0000, 4'b0101, 0);
`ifdef REGFILE_REQ_RSP_WSTRB_EN
        check("wstrb_reg0", {352'd0, regs_q[31:0]}, {352'd0, 32'hFF00_FF00});
`else
        check("wstrb_reg0", {352'd0, regs_q[31:0]}, {352'd0, 32'h0000_0000});
`endif

        // Random traffic
        for (int t = 0; t < 60; t++) begin
            do_req(1'($urandom_range(1, 0)), int'($urandom_range(15, 0)), $urandom,
                   4'($urandom_range(15, 0)), int'($urandom_range(3, 0)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
